// File: rtl/rom_toggle_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake ROM read port among N toggle-handshake clients.
// Optional per-client last-address hit cache is enabled by defining ROM_ARB_HIT_CACHE_EN.
module rom_toggle_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int AW        = 27,
  parameter int DW        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CLIENTS*AW-1:0] cl_addr,
  input  logic [N_CLIENTS-1:0]    cl_req,
  output logic [N_CLIENTS-1:0]    cl_ack,
  output logic [N_CLIENTS*DW-1:0] cl_data,
  output logic [AW-1:0]           mem_addr,
  output logic                    mem_req,
  input  logic                    mem_ack,
  input  logic [DW-1:0]           mem_data
);

  localparam int GW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [N_CLIENTS-1:0]    r_cl_ack;
  logic [N_CLIENTS*DW-1:0] r_cl_data;
  logic [AW-1:0]           r_mem_addr;
  logic                    r_mem_req;
  logic [GW-1:0]           r_gnt;
  logic [GW-1:0]           r_rr;

  logic [N_CLIENTS-1:0]    w_pending;
  logic                    w_found;
  logic [GW-1:0]           w_pick;
  logic [GW-1:0]           w_rr_next;
  logic [AW-1:0]           w_pick_addr;
  logic                    w_hit;
  logic                    w_issue;
  logic                    w_hit_ack;
  logic                    w_done;

  // base and off are both below N_CLIENTS, so a single subtraction wraps.
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CLIENTS) sum = sum - N_CLIENTS;
    return GW'(sum);
  endfunction

  assign w_pending   = cl_req ^ r_cl_ack;
  assign w_pick_addr = cl_addr[int'(w_pick)*AW +: AW];
  assign w_rr_next   = wrap_idx(w_pick, 1);

  // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (!w_found && w_pending[wrap_idx(r_rr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_idx(r_rr, k);
      end
    end
  end

`ifdef ROM_ARB_HIT_CACHE_EN
  logic [AW-1:0]        r_tag [N_CLIENTS];
  logic [N_CLIENTS-1:0] r_valid;

  assign w_hit = r_valid[w_pick] && (r_tag[w_pick] == w_pick_addr);

  always_ff @(posedge clk) begin
    if (reset)        r_valid         <= '0;
    else if (w_issue) r_valid[w_pick] <= 1'b1;
  end

  // NOTE: tags carry no reset; a tag is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_issue) r_tag[w_pick] <= w_pick_addr;
  end
`else
  assign w_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found && !w_hit) w_state_next = S_WAIT;
      S_WAIT:  if (mem_ack == r_mem_req) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_issue   = 1'b0;
    w_hit_ack = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_issue   = w_found && !w_hit;
        w_hit_ack = w_found &&  w_hit;
      end
      S_WAIT:  w_done = (mem_ack == r_mem_req);
      default: ;
    endcase
  end

  // Hit acks only happen in IDLE and completions only in WAIT, so the two ack writes never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cl_ack   <= '0;
      r_cl_data  <= '0;
      r_mem_addr <= '0;
      r_mem_req  <= 1'b0;
      r_gnt      <= '0;
      r_rr       <= '0;
    end else begin
      if (w_issue) begin
        r_mem_addr <= w_pick_addr;
        r_mem_req  <= ~r_mem_req;
        r_gnt      <= w_pick;
      end
      if (w_issue || w_hit_ack) r_rr <= w_rr_next;
      if (w_hit_ack) r_cl_ack[w_pick] <= ~r_cl_ack[w_pick];
      if (w_done) begin
        r_cl_data[int'(r_gnt)*DW +: DW] <= mem_data;
        r_cl_ack[r_gnt]                 <= ~r_cl_ack[r_gnt];
      end
    end
  end

  assign cl_ack   = r_cl_ack;
  assign cl_data  = r_cl_data;
  assign mem_addr = r_mem_addr;
  assign mem_req  = r_mem_req;

endmodule
